// File: rtl/fb_writer.sv
// Command-driven framebuffer writer: PIXEL / HLINE / FILL commands, one write per clock.
// Optional macro FB_WRITER_VLINE_EN turns opcode 11 into VLINE (otherwise NOP).
module fb_writer #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int COLOR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [X_W-1:0]       cmd_x,
    input  logic [Y_W-1:0]       cmd_y,
    input  logic [X_W-1:0]       cmd_arg,
    input  logic [COLOR_W-1:0]   cmd_color,
    output logic                 fb_we,
    output logic [X_W+Y_W-1:0]   fb_waddr,
    output logic [COLOR_W-1:0]   fb_din,
    output logic                 busy,
    output logic                 done
);
    localparam int AW = X_W + Y_W;

    localparam logic [1:0] OP_PIXEL = 2'b00;
    localparam logic [1:0] OP_HLINE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_VLINE = 2'b11;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_n;
    logic [1:0]           op_q, op_n;
    logic [X_W-1:0]       arg_q, arg_n;
    logic                 we_n, done_n, last;
    logic [AW-1:0]        addr_n, nxt;
    logic [COLOR_W-1:0]   din_n;
`ifdef FB_WRITER_VLINE_EN
    logic [Y_W-1:0]       arg_y, cmd_arg_y;
    assign arg_y     = Y_W'(arg_q);
    assign cmd_arg_y = Y_W'(cmd_arg);
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);

    always_comb begin
        state_n = state;
        op_n    = op_q;
        arg_n   = arg_q;
        we_n    = 1'b0;
        done_n  = 1'b0;
        addr_n  = fb_waddr;
        din_n   = fb_din;
        nxt     = fb_waddr + AW'(1);
        last    = 1'b1;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n   = cmd_op;
                    arg_n  = cmd_arg;
                    din_n  = cmd_color;
                    we_n   = 1'b1;
                    done_n = 1'b1;
                    addr_n = {cmd_y, cmd_x};
                    case (cmd_op)
                        OP_HLINE: begin
                            // arg <= x collapses to a single pixel; no wrap-around lines
                            if (cmd_arg > cmd_x) begin
                                done_n  = 1'b0;
                                state_n = RUN;
                            end
                        end
                        OP_FILL: begin
                            addr_n  = '0;
                            done_n  = 1'b0;
                            state_n = RUN;
                        end
                        OP_VLINE: begin
`ifdef FB_WRITER_VLINE_EN
                            if (cmd_arg_y > cmd_y) begin
                                done_n  = 1'b0;
                                state_n = RUN;
                            end
`else
                            we_n   = 1'b0;
                            addr_n = fb_waddr;
                            din_n  = fb_din;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // termination is checked on the address being written, so the counter never wraps
                case (op_q)
                    OP_HLINE: last = (nxt[X_W-1:0] == arg_q);
                    OP_FILL:  last = &nxt;
`ifdef FB_WRITER_VLINE_EN
                    OP_VLINE: begin
                        nxt  = fb_waddr + (AW'(1) << X_W);
                        last = (nxt[AW-1:X_W] == arg_y);
                    end
`endif
                    default:  last = 1'b1;
                endcase
                we_n   = 1'b1;
                addr_n = nxt;
                if (last) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            arg_q    <= '0;
            fb_we    <= 1'b0;
            fb_waddr <= '0;
            fb_din   <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            arg_q    <= arg_n;
            fb_we    <= we_n;
            fb_waddr <= addr_n;
            fb_din   <= din_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed scenarios plus randomized commands against a write-list model.
module tb_fb_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_x = '0, cmd_y = '0, cmd_arg = '0;
    logic [3:0]  cmd_color = '0;
    logic        fb_we;
    logic [11:0] fb_waddr;
    logic [3:0]  fb_din;
    logic        busy, done;

    fb_writer #(.X_W(6), .Y_W(6), .COLOR_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_arg(cmd_arg),
        .cmd_color(cmd_color), .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_din(fb_din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed activity
    logic [11:0] wa_q[$];
    logic [3:0]  wd_q[$];
    int          wc_q[$];
    logic [12:0] dn_q[$];
    int          busy_n, notready_n;
    // expected activity
    logic [11:0] ea_q[$];
    logic [3:0]  ed_q[$];
    logic [12:0] edn_q[$];
    logic [11:0] last_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (fb_we) begin
                wa_q.push_back(fb_waddr);
                wd_q.push_back(fb_din);
                wc_q.push_back(cyc);
            end
            if (done) dn_q.push_back({fb_we, fb_waddr});
            if (busy) busy_n++;
            if (!cmd_ready) notready_n++;
        end
    end

    // Each command produces a list of pixel writes and exactly one done event.
    function automatic void model(input logic [1:0] op, input logic [5:0] x, y, arg, input logic [3:0] c);
        int n = 0;
        case (op)
            2'd0: begin ea_q.push_back({y, x}); n++; end
            2'd1: begin
                if (arg > x) for (int i = x; i <= arg; i++) begin ea_q.push_back({y, 6'(i)}); n++; end
                else begin ea_q.push_back({y, x}); n++; end
            end
            2'd2: for (int i = 0; i < 4096; i++) begin ea_q.push_back(12'(i)); n++; end
            default: begin
`ifdef FB_WRITER_VLINE_EN
                if (arg > y) for (int j = y; j <= arg; j++) begin ea_q.push_back({6'(j), x}); n++; end
                else begin ea_q.push_back({y, x}); n++; end
`endif
            end
        endcase
        for (int i = 0; i < n; i++) ed_q.push_back(c);
        if (n > 0) last_addr = ea_q[$];
        edn_q.push_back({n > 0, last_addr});
    endfunction

    function automatic int first_bad();
        if (wa_q.size() != ea_q.size() || dn_q.size() != edn_q.size()) return -2;
        foreach (ea_q[i]) if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) return i;
        foreach (edn_q[i]) if (dn_q[i] !== edn_q[i]) return 100000 + i;
        return -1;
    endfunction

    task automatic clear_all();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); dn_q.delete();
        ea_q.delete(); ed_q.delete(); edn_q.delete();
        busy_n = 0; notready_n = 0;
    endtask

    // Presents a command and returns #1 after the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic [5:0] x, y, arg, input logic [3:0] c);
        int n = 0;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_arg = arg; cmd_color = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model(op, x, y, arg, c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 5000) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: cmd_ready=%b, required 1", cmd_ready);
        end
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({fb_we, busy, done, cmd_ready} !== 4'b0001) begin
            n_bad++; $display("FAIL reset_ctl: {we,busy,done,ready}=%b, required 0001", {fb_we, busy, done, cmd_ready});
        end
        n_cmp++;
        if ({fb_waddr, fb_din} !== 16'h0) begin
            n_bad++; $display("FAIL reset_data: addr=%h din=%h, required 000 0", fb_waddr, fb_din);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pixel();
        clear_all();
        send(2'd0, 6'd5, 6'd33, 6'd0, 4'hA);
        wait_idle();
        n_cmp++;
        if (wa_q.size() !== 1) begin
            n_bad++; $display("FAIL pixel_count: writes=%0d, required 1", wa_q.size());
        end else begin
            n_cmp++;
            if ({wa_q[0], wd_q[0]} !== 16'h845A) begin
                n_bad++; $display("FAIL pixel_write: addr=%h din=%h, required 845 a", wa_q[0], wd_q[0]);
            end
        end
        n_cmp++;
        if (dn_q.size() !== 1 || dn_q[0] !== 13'h1845) begin
            n_bad++; $display("FAIL pixel_done: n=%0d ev=%h, required 1 1845", dn_q.size(), dn_q.size() ? dn_q[0] : 13'h0);
        end
        n_cmp++;
        if (notready_n !== 0) begin
            n_bad++; $display("FAIL pixel_ready: low cycles=%0d, required 0", notready_n);
        end
    endtask

    task automatic test_back_to_back();
        int fb;
        clear_all();
        for (int i = 0; i < 3; i++)
            send(2'd0, 6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom));
        wait_idle();
        fb = first_bad();
        n_cmp++;
        if (fb !== -1) begin n_bad++; $display("FAIL b2b_seq: first bad=%0d, required -1", fb); end
        n_cmp++;
        if (wc_q.size() !== 3 || wc_q[2] - wc_q[0] !== 2) begin
            n_bad++; $display("FAIL b2b_spacing: writes=%0d, required 3 on consecutive cycles", wc_q.size());
        end
        n_cmp++;
        if (notready_n !== 0) begin n_bad++; $display("FAIL b2b_ready: low cycles=%0d, required 0", notready_n); end
    endtask

    task automatic test_hline();
        int fb;
        logic [11:0] exp_a;
        clear_all();
        send(2'd1, 6'd10, 6'd2, 6'd13, 4'd3);
        send(2'd0, 6'($urandom), 6'($urandom), 6'd0, 4'($urandom));
        wait_idle();
        n_cmp++;
        if (wa_q.size() !== 5) begin
            n_bad++; $display("FAIL hline_count: writes=%0d, required 5", wa_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_a = 12'h08A + 12'(i);
                n_cmp++;
                if (wa_q[i] !== exp_a || wd_q[i] !== 4'd3) begin
                    n_bad++; $display("FAIL hline_write%0d: addr=%h din=%h, required %h 3", i, wa_q[i], wd_q[i], exp_a);
                end
            end
            n_cmp++;
            if (wc_q[4] - wc_q[0] !== 4) begin
                n_bad++; $display("FAIL hline_next_accept: gap=%0d, required 4", wc_q[4] - wc_q[0]);
            end
        end
        n_cmp++;
        if (busy_n !== 3) begin n_bad++; $display("FAIL hline_busy: cycles=%0d, required 3", busy_n); end
        n_cmp++;
        if (dn_q.size() < 1 || dn_q[0] !== 13'h108D) begin
            n_bad++; $display("FAIL hline_done: ev=%h, required 108d", dn_q.size() ? dn_q[0] : 13'h0);
        end
        fb = first_bad();
        n_cmp++;
        if (fb !== -1) begin n_bad++; $display("FAIL hline_seq: first bad=%0d, required -1", fb); end
    endtask

    task automatic test_hline_degenerate();
        logic [5:0] y;
        y = 6'($urandom);
        clear_all();
        send(2'd1, 6'd20, y, 6'd7, 4'h6);
        wait_idle();
        n_cmp++;
        if (wa_q.size() !== 1 || wa_q[0] !== {y, 6'd20}) begin
            n_bad++; $display("FAIL hdeg_write: writes=%0d, required 1 at %h", wa_q.size(), {y, 6'd20});
        end
        n_cmp++;
        if (dn_q.size() !== 1 || busy_n !== 0) begin
            n_bad++; $display("FAIL hdeg_done: dones=%0d busy=%0d, required 1 0", dn_q.size(), busy_n);
        end
    endtask

    task automatic test_fill();
        int fb;
        clear_all();
        send(2'd2, 6'($urandom), 6'($urandom), 6'($urandom), 4'hF);
        wait_idle();
        fb = first_bad();
        n_cmp++;
        if (fb !== -1) begin n_bad++; $display("FAIL fill_seq: first bad=%0d writes=%0d, required -1 4096", fb, wa_q.size()); end
        n_cmp++;
        if (dn_q.size() !== 1 || dn_q[0] !== 13'h1FFF) begin
            n_bad++; $display("FAIL fill_done: n=%0d, required one event at fff", dn_q.size());
        end
        n_cmp++;
        if (busy_n !== 4095) begin n_bad++; $display("FAIL fill_busy: cycles=%0d, required 4095", busy_n); end
    endtask

    task automatic test_fill_reset();
        int n = 0;
        clear_all();
        send(2'd2, 6'd0, 6'd0, 6'd0, 4'h5);
        while (wa_q.size() < 100 && n < 500) begin @(negedge clk); n++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({fb_we, busy, cmd_ready} !== 3'b001) begin
            n_bad++; $display("FAIL rst_abort: {we,busy,ready}=%b, required 001", {fb_we, busy, cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        last_addr = '0;
        clear_all();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wa_q.size() !== 0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_after: writes=%0d ready=%b, required 0 1", wa_q.size(), cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_op3();
        int fb;
        clear_all();
        send(2'd3, 6'd4, 6'd0, 6'd2, 4'h9);
        wait_idle();
`ifdef FB_WRITER_VLINE_EN
        n_cmp++;
        if (wa_q.size() !== 3 || wa_q[0] !== 12'h004 || wa_q[1] !== 12'h044 || wa_q[2] !== 12'h084) begin
            n_bad++; $display("FAIL vline_write: writes=%0d, required 004 044 084", wa_q.size());
        end
`else
        n_cmp++;
        if (wa_q.size() !== 0 || dn_q.size() !== 1) begin
            n_bad++; $display("FAIL nop: writes=%0d dones=%0d, required 0 1", wa_q.size(), dn_q.size());
        end
`endif
        fb = first_bad();
        n_cmp++;
        if (fb !== -1) begin n_bad++; $display("FAIL op3_seq: first bad=%0d, required -1", fb); end
    endtask

    task automatic test_random();
        int fb;
        logic [1:0] op;
        clear_all();
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 2));
            if (op == 2'd2) op = 2'd3;
            send(op, 6'($urandom), 6'($urandom), 6'($urandom), 4'($urandom));
        end
        wait_idle();
        fb = first_bad();
        n_cmp++;
        if (fb !== -1) begin n_bad++; $display("FAIL random_seq: first bad=%0d, required -1", fb); end
        n_cmp++;
        if (dn_q.size() !== 40) begin n_bad++; $display("FAIL random_done: dones=%0d, required 40", dn_q.size()); end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_back_to_back();
        test_hline();
        test_hline_degenerate();
        test_fill();
        test_fill_reset();
        test_op3();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fb_writer.md
# fb_writer

Command-driven write port for the dual-half LED framebuffer: accepts pixel, horizontal-line and full-clear commands over a valid/ready handshake and emits one framebuffer write per clock. Sits directly upstream of the framebuffer write port (`waddr`/`din`/`we`), with `ce` tied high at top level, while the LED scan controller owns the read side. Lets a CPU or test pattern generator update the display image without knowing the half/row/column address layout.

## Interface
Parameters:
- `X_W`, default 6: column coordinate width (64 columns).
- `Y_W`, default 6: display row width (64 rows; MSB selects the upper or lower panel half).
- `COLOR_W`, default 4: pixel value width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  opcode: 00 PIXEL, 01 HLINE, 10 FILL, 11 VLINE or NOP (see Configuration).
- `cmd_x`  in  X_W  start column.
- `cmd_y`  in  Y_W  start row.
- `cmd_arg`  in  X_W  end coordinate, inclusive (column for HLINE, row for VLINE).
- `cmd_color`  in  COLOR_W  pixel value.
- `fb_we`  out  1  framebuffer write strobe.
- `fb_waddr`  out  X_W+Y_W  write address, `{y, x}`, i.e. `{half, row[4:0], col[5:0]}`.
- `fb_din`  out  COLOR_W  write data.
- `busy`  out  1  multi-cycle command in progress.
- `done`  out  1  one-cycle pulse coincident with the last write of each command.

## Operation
- States:
  - IDLE: `cmd_ready` = 1.
  - RUN: `cmd_ready` = 0, `busy` = 1.
  - `cmd_ready` is combinational from state only; it does not depend on `cmd_valid`.
- A command is accepted on a rising edge with `cmd_valid && cmd_ready`. Opcode, coordinates, `cmd_arg` and colour are latched at that edge.
- Accept edge actions, all registered:
  - `fb_we` = 1.
  - `fb_din` = colour.
  - `fb_waddr` = first address.
- PIXEL: writes address `{cmd_y, cmd_x}` and stays in IDLE. `done` = 1 at the same edge.
- HLINE:
  - First address is `{cmd_y, cmd_x}`.
  - If `cmd_arg` > `cmd_x`: go to RUN. Each RUN edge increments x; on the edge where x == `cmd_arg`, return to IDLE with `done` = 1.
  - If `cmd_arg` <= `cmd_x`: degenerate case, single pixel at `cmd_x` only. Behaves like PIXEL. No wrap.
- FILL:
  - `cmd_x`, `cmd_y` and `cmd_arg` are ignored.
  - Writes addresses 0 to 4095 in order, one per cycle (4096 writes total).
  - `done` = 1 with the write to address 4095; returns to IDLE at that edge.
- `fb_we` = 0 on every edge with no write. `fb_waddr` and `fb_din` hold their last values.
- `busy` = (state == RUN).
- The address counter is X_W+Y_W bits. It never wraps during a command, because termination is compared before increment.

## Timing
- Reset values (asynchronous, take effect immediately):
  - State IDLE, so `cmd_ready` = 1.
  - `fb_we` = 0, `fb_waddr` = 0, `fb_din` = 0.
  - `busy` = 0, `done` = 0.
- Write latency: the first write is visible one edge after acceptance, i.e. the outputs update at the accept edge.
- Throughput:
  - PIXEL: back-to-back at 1 per clock (`cmd_ready` stays high).
  - HLINE from x0 to x1: x1−x0+1 cycles. The next command can be accepted at the edge after `done`.
  - FILL: 4096 cycles.
- A `cmd_valid` asserted while in RUN is ignored and not lost; the source holds it until `cmd_ready`.
- Reset asserted mid-command aborts the command. No further writes; outputs take reset values asynchronously.
- Framebuffer writes and LED controller reads are not arbitrated. Tearing is acceptable.

## Configuration
- `FB_WRITER_VLINE_EN` defined: opcode 11 is VLINE.
  - Column `cmd_x` fixed; y steps from `cmd_y` to `cmd_arg` inclusive, +1 per cycle.
  - `cmd_arg` is zero-extended to Y_W when Y_W > X_W.
  - Degenerate case (`cmd_arg` <= `cmd_y`): single pixel only.
  - Same `done`/`busy` rules as HLINE.
- Not defined: opcode 11 is NOP.
  - Accepted in one cycle; no write (`fb_we` = 0).
  - `done` = 1 at the accept edge; state stays IDLE.

## Test plan
- Reset, then PIXEL x=5, y=33, colour=0xA → one write, `fb_waddr`=0x845, `fb_din`=0xA, `done` at the same edge, `cmd_ready` never drops.
- Three PIXEL commands on consecutive cycles → three consecutive `fb_we` pulses with matching addresses, no stall.
- HLINE y=2, x=10, arg=13, colour=3 → writes 0x08A, 0x08B, 0x08C, 0x08D on 4 consecutive cycles; `busy` high for 3 cycles; `done` with 0x08D; `cmd_valid` held during RUN is accepted at the edge after `done`.
- HLINE x=20, arg=7 → exactly one write at x=20; `done` at the same edge.
- FILL colour=0xF → 4096 writes covering 0x000–0xFFF exactly once; `done` with 0xFFF. Assert `rst` after 100 writes in a rerun → `fb_we`=0 immediately, `cmd_ready`=1 after release.
- Opcode 11, x=4, y=0, arg=2:
  - With `FB_WRITER_VLINE_EN`: writes 0x004, 0x044, 0x084.
  - Without it: no write, `done` pulse only.
